switch_alloc: RTL and testbench
===============================

# switch_alloc

Wormhole switch allocator that drives the crossbar's `select_array`. Each input port presents a one-hot output-port request. Each output port picks one requesting input per packet by round-robin, holds that connection from head flit to tail flit, and reports per-input grants and per-output valid. It sits between the input buffers and the crossbar of each router.

## Interface
- `INPORT`, 5, number of input ports
- `OUTPORT`, 5, number of output ports
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `in_valid`  in  [0:INPORT-1]  input j has a flit at its buffer head
- `in_tail`  in  [0:INPORT-1]  the flit at input j is a tail (a single-flit packet has tail=1)
- `req_array`  in  [0:INPORT*OUTPORT-1]  bits j*OUTPORT+o: input j requests output o; one-hot; qualified by `in_valid[j]`
- `out_ready`  in  [0:OUTPORT-1]  downstream of output o accepts a flit this cycle
- `select_array`  out  [0:OUTPORT*INPORT-1]  registered; bit o*INPORT+j=1 means output o is connected to input j; at most one bit per output group
- `out_valid`  out  [0:OUTPORT-1]  combinational; output o carries a valid flit
- `in_gnt`  out  [0:INPORT-1]  combinational; the flit at input j transfers this cycle, so input j pops it

## Operation
- Per-output state: IDLE, or LOCKED(owner j). Per-output round-robin pointer `ptr[o]` in 0..INPORT-1.
- IDLE, output o: eligible inputs are all j with `in_valid[j]` and `req_array[j*OUTPORT+o]`.
  - Winner = first eligible j scanning ptr[o], ptr[o]+1, … modulo INPORT.
  - On the next edge: LOCKED(winner), and `select_array` bit o*INPORT+winner is set.
  - If nothing is eligible, the output stays IDLE.
- LOCKED(j), output o:
  - `out_valid[o] = in_valid[j]`.
  - Transfer occurs when `out_valid[o] && out_ready[o]`; `in_gnt[j]` = transfer.
  - A transfer with `in_tail[j]=1` releases the lock: on the next edge the output goes IDLE, the select group clears, and `ptr[o] = (j+1) mod INPORT`.
  - Requests from other inputs are ignored while locked.
- `ptr[o]` changes only on tail release.
- Outputs arbitrate independently. An input whose request is one-hot can own at most one output.
- Protocol, guaranteed by the sender:
  - `req_array` row j is one-hot and stable from head to tail.
  - `in_valid` may drop between flits. The lock is held across the gap, and `out_valid` is low during it.
- Multi-hot row (protocol violation): input j is considered only for its lowest-indexed requested output.
- `in_gnt[j]`, `out_valid[o]`: 0 when no output is locked to j / when o is IDLE.

## Timing
- Reset values: `select_array` = 0, `out_valid` = 0, `in_gnt` = 0, all outputs IDLE, all `ptr` = 0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-packet: the lock is dropped at once and no tail is required. The sender flushes separately.
- Latency: a request visible at edge N gives `select`, `out_valid` and `in_gnt` in cycle N+1. If `out_ready=1`, the first flit transfers in cycle N+1.
- Tail transfers in cycle M → select clears in cycle M+1. A new winner is chosen during cycle M+1 and its select appears in M+2. This is one bubble per packet switch on a contended output.
- Backpressure (`out_ready=0`): `in_gnt` is low and select and lock are held. There is no timeout.
- A head and the release tail on different outputs in the same cycle are independent.
- `in_gnt` and `out_valid` have combinational paths from `in_valid` and `out_ready` only. The path from `req_array` is registered.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle while output 2 is locked to input 1 → `select_array`=0 and `out_valid`=0 immediately. After release, an input-1 request on output 2 arbitrates from `ptr`=0.
- Single flit: input 2 requests output 3, tail=1, `out_ready`=1 at edge 1 → cycle 1 `select_array` bit 17=1, `out_valid[3]`=1, `in_gnt[2]`=1. Cycle 2: select=0 and `ptr[3]`=3.
- Round-robin: inputs 0, 1, 4 hold single-flit requests to output 1 continuously, refilling after each grant → grant order 0, 1, 4, 0, 1, with grants 2 cycles apart.
- Wormhole lock: input 3 sends a 4-flit packet to output 0. Input 1 requests output 0 one cycle after input 3's head. Expected:
  - Four consecutive `in_gnt[3]` and no `in_gnt[1]`.
  - Select bit 1 appears 2 cycles after the tail.
  - Final `ptr[0]`=4.
- Backpressure and gaps:
  - Drop `out_ready[0]` for 3 cycles mid-packet → `in_gnt`=0 and select held.
  - Drop `in_valid` for 2 cycles → `out_valid`=0 and the lock is retained.
- Parallel: inputs 0→4 and 4→0 request in the same cycle → both selects are set the next cycle (bits 20 and 4), and both transfer concurrently.

Source files
------------

// File: rtl/switch_alloc.sv
// Wormhole switch allocator: per-output round-robin arbitration with a lock held
// from head flit to tail flit; drives the crossbar select matrix.
module switch_alloc #(
   parameter int INPORT  = 5,
   parameter int OUTPORT = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [0:INPORT-1]            in_valid,
   input  logic [0:INPORT-1]            in_tail,
   input  logic [0:INPORT*OUTPORT-1]    req_array,
   input  logic [0:OUTPORT-1]           out_ready,
   output logic [0:OUTPORT*INPORT-1]    select_array,
   output logic [0:OUTPORT-1]           out_valid,
   output logic [0:INPORT-1]            in_gnt
);

   localparam int PW = (INPORT > 1) ? $clog2(INPORT) : 1;

   logic [0:OUTPORT*INPORT-1] sel_q, sel_d;
   logic [PW-1:0]             ptr_q [OUTPORT];
   logic [PW-1:0]             ptr_d [OUTPORT];
   logic [0:INPORT*OUTPORT-1] req_eff;

   // A multi-hot row competes only for its lowest-indexed output.
   always_comb begin
      logic seen;
      req_eff = '0;
      seen    = 1'b0;
      for (int j = 0; j < INPORT; j++) begin
         seen = 1'b0;
         for (int o = 0; o < OUTPORT; o++) begin
            if (!seen && req_array[j*OUTPORT+o]) begin
               req_eff[j*OUTPORT+o] = 1'b1;
               seen                 = 1'b1;
            end
         end
      end
   end

   always_comb begin
      logic locked;
      logic hit;
      int   own;
      int   idx;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      out_valid = '0;
      in_gnt    = '0;
      locked    = 1'b0;
      hit       = 1'b0;
      own       = 0;
      idx       = 0;
      for (int o = 0; o < OUTPORT; o++) begin
         locked = 1'b0;
         own    = 0;
         for (int j = 0; j < INPORT; j++) begin
            if (sel_q[o*INPORT+j]) begin
               locked = 1'b1;
               own    = j;
            end
         end
         if (locked) begin
            // Lock persists across in_valid gaps; only a transferred tail releases it.
            out_valid[o] = in_valid[own];
            if (in_valid[own] && out_ready[o]) begin
               in_gnt[own] = 1'b1;
               if (in_tail[own]) begin
                  for (int j = 0; j < INPORT; j++) sel_d[o*INPORT+j] = 1'b0;
                  ptr_d[o] = (own == INPORT-1) ? '0 : PW'(own + 1);
               end
            end
         end else begin
            hit = 1'b0;
            for (int k = 0; k < INPORT; k++) begin
               idx = int'(ptr_q[o]) + k;
               if (idx >= INPORT) idx = idx - INPORT;
               if (!hit && in_valid[idx] && req_eff[idx*OUTPORT+o]) begin
                  sel_d[o*INPORT+idx] = 1'b1;
                  hit                 = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q <= '0;
         for (int o = 0; o < OUTPORT; o++) ptr_q[o] <= '0;
      end else begin
         sel_q <= sel_d;
         ptr_q <= ptr_d;
      end
   end

   assign select_array = sel_q;

endmodule

// File: tb/tb_switch_alloc.sv
// Directed bench for switch_alloc: reset, single flit, round-robin, wormhole lock,
// backpressure and gaps, parallel connections, and asynchronous reset mid-packet.
module tb_switch_alloc;

   logic        clk;
   logic        rst;
   logic [0:4]  in_valid;
   logic [0:4]  in_tail;
   logic [0:24] req_array;
   logic [0:4]  out_ready;
   logic [0:24] select_array;
   logic [0:4]  out_valid;
   logic [0:4]  in_gnt;

   int total = 0;
   int bad   = 0;

   switch_alloc #(.INPORT(5), .OUTPORT(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_tail      (in_tail),
      .req_array    (req_array),
      .out_ready    (out_ready),
      .select_array (select_array),
      .out_valid    (out_valid),
      .in_gnt       (in_gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [0:24] sb(input int o, input int j);
      logic [0:24] v;
      v = '0;
      v[o*5+j] = 1'b1;
      return v;
   endfunction

   function automatic logic [0:4] oh(input int j);
      logic [0:4] v;
      v = '0;
      if (j >= 0) v[j] = 1'b1;
      return v;
   endfunction

   task automatic clr();
      in_valid  = '0;
      in_tail   = '0;
      req_array = '0;
   endtask

   task automatic rq(input int j, input int o, input logic tl);
      in_valid[j]       = 1'b1;
      in_tail[j]        = tl;
      req_array[j*5+o]  = 1'b1;
   endtask

   task automatic drop(input int j);
      in_valid[j] = 1'b0;
      in_tail[j]  = 1'b0;
      for (int o = 0; o < 5; o++) req_array[j*5+o] = 1'b0;
   endtask

   task automatic chk_all(input string tag, input logic [0:24] s, input logic [0:4] ov,
                          input logic [0:4] g);
      check({tag, "_sel"}, {7'b0, select_array}, {7'b0, s});
      check({tag, "_ovld"}, {27'b0, out_valid}, {27'b0, ov});
      check({tag, "_gnt"}, {27'b0, in_gnt}, {27'b0, g});
   endtask

   int rr_order [9] = '{0, -1, 1, -1, 4, -1, 0, -1, 1};

   initial begin
      rst       = 1'b1;
      out_ready = 5'b11111;
      clr();
      #1;
      chk_all("reset", '0, '0, '0);
      tick();
      tick();
      rst = 1'b0;

      // Single flit 2 -> 3
      rq(2, 3, 1'b1);
      #1;
      check("sf_pre_sel", {7'b0, select_array}, 32'd0);
      tick();
      #1;
      chk_all("sf_c1", sb(3, 2), oh(3), oh(2));
      tick();
      clr();
      #1;
      chk_all("sf_c2", '0, '0, '0);
      // ptr[3] is now 3: input 3 beats input 2
      rq(2, 3, 1'b1);
      rq(3, 3, 1'b1);
      tick();
      #1;
      chk_all("ptr3_c1", sb(3, 3), oh(3), oh(3));
      tick();
      drop(3);
      #1;
      check("ptr3_c2_sel", {7'b0, select_array}, 32'd0);
      tick();
      #1;
      chk_all("ptr3_c3", sb(3, 2), oh(3), oh(2));
      tick();
      clr();
      tick();

      // Round-robin on output 1
      rq(0, 1, 1'b1);
      rq(1, 1, 1'b1);
      rq(4, 1, 1'b1);
      for (int c = 0; c < 9; c++) begin
         tick();
         #1;
         check($sformatf("rr_c%0d_gnt", c + 1), {27'b0, in_gnt}, {27'b0, oh(rr_order[c])});
      end
      tick();
      clr();
      tick();

      // Wormhole: input 3 four flits to output 0, input 1 contends
      rq(3, 0, 1'b0);
      tick();
      rq(1, 0, 1'b0);
      #1;
      chk_all("wh_c1", sb(0, 3), oh(0), oh(3));
      tick();
      #1;
      chk_all("wh_c2", sb(0, 3), oh(0), oh(3));
      tick();
      #1;
      chk_all("wh_c3", sb(0, 3), oh(0), oh(3));
      tick();
      in_tail[3] = 1'b1;
      #1;
      chk_all("wh_c4", sb(0, 3), oh(0), oh(3));
      tick();
      drop(3);
      in_tail[1] = 1'b1;
      #1;
      chk_all("wh_c5", '0, '0, '0);
      tick();
      #1;
      chk_all("wh_c6", sb(0, 1), oh(0), oh(1));
      tick();
      clr();
      #1;
      check("wh_c7_sel", {7'b0, select_array}, 32'd0);

      // Backpressure and valid gaps, input 2 -> output 0, input 3 contends while locked
      rq(2, 0, 1'b0);
      tick();
      #1;
      chk_all("bp_c1", sb(0, 2), oh(0), oh(2));
      out_ready[0] = 1'b0;
      rq(3, 0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         chk_all($sformatf("bp_stall%0d", c), sb(0, 2), oh(0), '0);
      end
      tick();
      out_ready[0] = 1'b1;
      in_valid[2]  = 1'b0;
      #1;
      chk_all("gap_c5", sb(0, 2), '0, '0);
      tick();
      #1;
      chk_all("gap_c6", sb(0, 2), '0, '0);
      tick();
      in_valid[2] = 1'b1;
      in_tail[2]  = 1'b1;
      #1;
      chk_all("gap_c7", sb(0, 2), oh(0), oh(2));
      tick();
      drop(2);
      #1;
      check("gap_c8_sel", {7'b0, select_array}, 32'd0);
      tick();
      #1;
      chk_all("gap_c9", sb(0, 3), oh(0), oh(3));
      tick();
      clr();
      tick();

      // Parallel 0 -> 4 and 4 -> 0
      rq(0, 4, 1'b1);
      rq(4, 0, 1'b1);
      tick();
      #1;
      chk_all("par_c1", sb(4, 0) | sb(0, 4), 5'b10001, 5'b10001);
      tick();
      clr();
      #1;
      check("par_c2_sel", {7'b0, select_array}, 32'd0);

      // Move ptr[2] to 4, then lock 1 -> 2 and reset mid-packet
      rq(3, 2, 1'b1);
      tick();
      #1;
      check("rs_pre_gnt", {27'b0, in_gnt}, {27'b0, oh(3)});
      tick();
      clr();
      tick();
      rq(1, 2, 1'b0);
      tick();
      #1;
      chk_all("rs_lock", sb(2, 1), oh(2), oh(1));
      #3;
      rst = 1'b1;
      #1;
      chk_all("rs_async", '0, '0, '0);
      #1;
      rst = 1'b0;
      clr();
      rq(1, 2, 1'b1);
      rq(4, 2, 1'b1);
      tick();
      #1;
      chk_all("rs_after", sb(2, 1), oh(2), oh(1));
      tick();
      clr();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
